// File: rtl/result_accumulator.sv
// Block accumulator for the add/sub result stream: sums COUNT samples and presents the sum on a valid/ready port.
// Optional build macro RESULT_ACCUM_SAT_EN selects a saturating accumulator; when undefined the accumulator wraps.
module result_accumulator #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int COUNT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_signed,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   // state | meaning
   // ACCUM | taking samples into acc, cnt counts accepted samples
   // HOLD  | block sum presented on out_sum, waiting for out_ready
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic [ACC_W-1:0] out_sum_nxt;
   logic             out_ovf_nxt;

   logic [ACC_W-1:0] sample_ext;
   logic [ACC_W-1:0] sum_raw;
   logic [ACC_W-1:0] sum_next;
   logic             add_ovf;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   always_comb begin
      sample_ext = {{(ACC_W-DATA_W){1'b0}}, in_data};
      if (in_signed) begin
         sample_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      end
      sum_raw = acc + sample_ext;
      add_ovf = (acc[ACC_W-1] == sample_ext[ACC_W-1]) &&
                (sum_raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef RESULT_ACCUM_SAT_EN
      // Clamp toward the sign of the operands; later samples build on the clamped value.
      if (add_ovf) begin
         sum_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_next = sum_raw;
      end
`else
      sum_next = sum_raw;
`endif
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      ovf_nxt     = ovf;
      out_sum_nxt = out_sum;
      out_ovf_nxt = out_ovf;
      case (state)
         ACCUM: begin
            if (in_valid) begin
               acc_nxt = sum_next;
               ovf_nxt = ovf | add_ovf;
               if (cnt == CNT_LAST) begin
                  state_nxt   = HOLD;
                  cnt_nxt     = '0;
                  out_sum_nxt = sum_next;
                  out_ovf_nxt = ovf | add_ovf;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt   = ACCUM;
               acc_nxt     = '0;
               ovf_nxt     = 1'b0;
               out_ovf_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else begin
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         ovf     <= ovf_nxt;
         out_sum <= out_sum_nxt;
         out_ovf <= out_ovf_nxt;
      end
   end

endmodule

// File: doc/result_accumulator.md
# result_accumulator

Downstream consumer of the registered 8-bit add/subtract result stream. Accumulates a fixed number of accepted samples into a wider signed accumulator, then presents the block sum on a valid/ready output port with a sticky overflow flag. Sits directly after the add/sub stage. Feeds software-visible statistics and checker logic.

## Interface
- `DATA_W`, default 8: input sample width.
- `ACC_W`, default 16: accumulator/output width. Must satisfy ACC_W > DATA_W.
- `COUNT`, default 4: samples per block. Must satisfy COUNT >= 1.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: sample present.
- `in_data` in DATA_W: sample (add/sub result).
- `in_signed` in 1: 1 = sample is two's complement (sign-extend); 0 = unsigned (zero-extend). Sampled per beat.
- `in_ready` out 1: block can accept a sample.
- `out_valid` out 1: block sum available.
- `out_ready` in 1: consumer takes sum.
- `out_sum` out ACC_W: signed block sum.
- `out_ovf` out 1: signed overflow occurred during this block (sticky per block).

## Operation
- There are two states:
  - ACCUM (reset state).
  - HOLD.
- `in_ready` = (state == ACCUM). It is decoded from state only and has no combinational path from `out_ready`.
- **Accept:** `in_valid && in_ready` at a posedge.
  - The sample is extended to ACC_W per `in_signed` and added to `acc`.
  - `cnt` increments.
  - Gaps in `in_valid` are allowed. `acc` and `cnt` hold.
- **Block complete:** the accept that brings `cnt` to COUNT causes the following:
  - The state moves to HOLD.
  - `out_sum` is loaded with the final sum.
  - `out_valid` is set.
  - `cnt` clears.
- **HOLD:**
  - `in_ready` is 0. `in_valid`/`in_data` are ignored.
  - `out_sum` and `out_ovf` are stable.
- **Output handshake:** `out_valid && out_ready` at a posedge causes the following:
  - `out_valid` clears.
  - `acc` clears.
  - `out_ovf` clears.
  - The state returns to ACCUM. The first new sample can be accepted on the next cycle.
- **Arithmetic:** `acc` is ACC_W two's complement.
  - Overflow = both operands have the same sign and the result sign differs.
  - Overflow sets the sticky `ovf`, which is copied to `out_ovf` at block complete.
- **Reset** (any time, including mid-block or in HOLD): all state returns to reset values immediately. A partially accumulated block is discarded.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_sum` = 0.
  - `out_ovf` = 0.
  - Internal `acc` = 0, `cnt` = 0, state = ACCUM.
- **Latency:** `out_valid` rises the cycle after the COUNT-th accept.
- **Minimum block period:** COUNT + 1 cycles with `out_ready` tied high, i.e. COUNT accept cycles plus 1 HOLD cycle.
- **Backpressure:** `out_valid` holds until a handshake occurs. No sample is lost, because upstream sees `in_ready` = 0 and holds its data.
- **COUNT = 1:** every accept goes directly to HOLD.
- `out_ready` asserted while `out_valid` = 0 has no effect.

## Configuration
- Macro: `RESULT_ACCUM_SAT_EN`.
- **Defined:** on overflow, `acc` saturates.
  - Positive overflow clamps to 2^(ACC_W-1)-1.
  - Negative overflow clamps to -2^(ACC_W-1).
  - Later samples add to the clamped value.
  - `out_ovf` is still set.
- **Undefined:** the accumulator wraps modulo 2^ACC_W. `out_ovf` is still set.
- Handshake and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst` mid-block after 2 accepts, then release and send 4 samples of 8'h01 (unsigned) -> `out_sum` = 16'h0004. All outputs read 0 and `in_ready` reads 1 during reset.
- **Unsigned:** 4 samples of 8'hFF, `in_signed` = 0, `out_ready` = 1 -> `out_valid` pulses 1 cycle after the 4th accept, `out_sum` = 16'h03FC, `out_ovf` = 0. The next block is accepted the cycle after.
- **Signed:** 4 samples of 8'hFF, `in_signed` = 1 -> `out_sum` = 16'hFFFC (-4), `out_ovf` = 0.
- **Backpressure:** complete a block, hold `out_ready` = 0 for 3 cycles while driving `in_valid` = 1 with 8'h05 -> `out_valid`/`out_sum` stay stable, `in_ready` = 0, no sample counted. After `out_ready` is raised, the next block sums only the post-handshake samples.
- **Overflow** (ACC_W = 10): 4 samples of 8'hFF unsigned.
  - With `RESULT_ACCUM_SAT_EN` -> `out_sum` = 10'h1FF, `out_ovf` = 1.
  - Without -> `out_sum` = 10'h3FC, `out_ovf` = 1.
  - Following block of 4 samples of 8'h00 -> `out_ovf` = 0.
- **Gaps:** 4 samples of 8'h02 with `in_valid` toggling every other cycle -> `out_sum` = 16'h0008, `out_valid` the cycle after the 4th accept.
